// File: rtl/des_decrypt_key_scheduler.sv
// des_decrypt_key_scheduler: DES subkeys K16..K1 with a valid/ack handshake.
// Define DES_KEY_PARITY_CHECK_EN to add a LOAD cycle that checks key byte parity.
module des_decrypt_key_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_strobe_din,
  input  logic [0:63] key_din,
  input  logic        round_key_ack_din,
  output logic [0:47] round_key_dout,
  output logic        round_key_valid_dout,
  output logic [3:0]  round_number_dout,
  output logic        busy_dout,
  output logic        done_strobe_dout,
  output logic        parity_error_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef DES_KEY_PARITY_CHECK_EN
    LOAD  = 2'd1,
`endif
    ROUND = 2'd2
  } state_t;

  // FIPS 46-3 permuted choice 1, 1-based, bit 1 = MSB
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // FIPS 46-3 permuted choice 2, 1-based over {C,D}
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state;
  logic [0:27] c_q;
  logic [0:27] d_q;
  logic [0:55] pc1_w;
  logic [0:55] cd_w;
  logic        one_step;

  // The encryption schedule rotates left; walking it backwards rotates right.
  function automatic logic [0:27] rotr(
    input logic [0:27] v,
    input logic        single
  );
    if (single) begin
      return {v[27], v[0:26]};
    end
    return {v[26:27], v[0:25]};
  endfunction

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_w[i] = key_din[PC1[i] - 1];
  end

  assign cd_w = {c_q, d_q};

  // Subkey is pure wiring of the C/D registers.
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign round_key_dout[i] = cd_w[PC2[i] - 1];
  end

  // Rounds 16, 9, 2 and 1 use a single-bit shift.
  assign one_step = (round_number_dout == 4'd0)
                 || (round_number_dout == 4'd9)
                 || (round_number_dout == 4'd2)
                 || (round_number_dout == 4'd1);

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] key_par;
  logic [7:0] par_q;

  for (genvar b = 0; b < 8; b++) begin : g_par
    assign key_par[b] = ^key_din[8*b +: 8];
  end
`else
  logic unused_parity_bits;

  assign unused_parity_bits = ^{
    key_din[7],  key_din[15],
    key_din[23], key_din[31],
    key_din[39], key_din[47],
    key_din[55], key_din[63]
  };
  assign parity_error_dout = 1'b0;
`endif

  // Schedule FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      c_q                  <= '0;
      d_q                  <= '0;
      round_key_valid_dout <= 1'b0;
      round_number_dout    <= 4'd0;
      busy_dout            <= 1'b0;
      done_strobe_dout     <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      par_q                <= '0;
      parity_error_dout    <= 1'b0;
`endif
    end else begin
      done_strobe_dout <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      parity_error_dout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start_strobe_din) begin
            c_q       <= pc1_w[0:27];
            d_q       <= pc1_w[28:55];
            busy_dout <= 1'b1;
`ifdef DES_KEY_PARITY_CHECK_EN
            par_q     <= key_par;
            state     <= LOAD;
`else
            state                <= ROUND;
            round_key_valid_dout <= 1'b1;
            round_number_dout    <= 4'd0;
`endif
          end
        end
`ifdef DES_KEY_PARITY_CHECK_EN
        LOAD: begin
          if (&par_q) begin
            state                <= ROUND;
            round_key_valid_dout <= 1'b1;
            round_number_dout    <= 4'd0;
          end else begin
            state             <= IDLE;
            busy_dout         <= 1'b0;
            parity_error_dout <= 1'b1;
          end
        end
`endif
        ROUND: begin
          if (round_key_ack_din) begin
            c_q <= rotr(c_q, one_step);
            d_q <= rotr(d_q, one_step);
            round_number_dout <= round_number_dout - 4'd1;
            if (round_number_dout == 4'd1) begin
              state                <= IDLE;
              round_key_valid_dout <= 1'b0;
              busy_dout            <= 1'b0;
              done_strobe_dout     <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_key_scheduler.sv
// tb_des_decrypt_key_scheduler: vector table, corner sequences and
// random keys checked against a forward FIPS 46-3 key schedule model.
module tb_des_decrypt_key_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [0:63] key = '0;
  logic        ack = 1'b0;
  logic [0:47] rk;
  logic        valid;
  logic [3:0]  rn;
  logic        busy;
  logic        done;
  logic        perr;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  des_decrypt_key_scheduler dut (
    .clk                  (clk),
    .reset                (reset),
    .start_strobe_din     (start),
    .key_din              (key),
    .round_key_ack_din    (ack),
    .round_key_dout       (rk),
    .round_key_valid_dout (valid),
    .round_number_dout    (rn),
    .busy_dout            (busy),
    .done_strobe_dout     (done),
    .parity_error_dout    (perr)
  );

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SH [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2,
    1, 2, 2, 2, 2, 2, 2, 1
  };

  typedef struct {
    logic [0:63] key;
    logic [0:47] k16;
    logic [0:47] k1;
  } vec_t;

  vec_t        tbl [3];
  logic [0:47] mk [1:16];
  logic [0:47] g16;
  logic [0:47] g1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Forward encryption schedule: K1..K16 via left rotations.
  task automatic model(input logic [0:63] k);
    logic [0:27] c;
    logic [0:27] d;
    logic [0:55] cd;
    for (int i = 0; i < 28; i++) begin
      c[i] = k[PC1[i] - 1];
      d[i] = k[PC1[i + 28] - 1];
    end
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < SH[r - 1]; s++) begin
        c = {c[1:27], c[0]};
        d = {d[1:27], d[0]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) mk[r][j] = cd[PC2[j] - 1];
    end
  endtask

  task automatic run_sched(output logic [0:47] got16,
                           output logic [0:47] got1,
                           input logic [0:63] k,
                           input int stall_at,
                           input int stall_len,
                           input int intr_at,
                           input logic [0:63] intr_key,
                           input bit chain,
                           input logic [0:63] chain_key,
                           input bit pre);
    model(k);
    got16 = '0;
    got1 = '0;
    ack = 1'b1;
    if (!pre) begin
      start = 1'b1;
      key = k;
      step();
    end
    start = 1'b0;
    key = ~k;
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("load valid", {63'd0, valid}, 64'd0);
    chk("load busy", {63'd0, busy}, 64'd1);
    step();
`endif
    for (int n = 16; n >= 1; n--) begin
      if (n == 16) got16 = rk;
      if (n == 1) got1 = rk;
      chk($sformatf("K%0d key", n), {16'd0, rk}, {16'd0, mk[n]});
      chk($sformatf("K%0d num", n), {60'd0, rn}, {60'd0, 4'(n)});
      chk($sformatf("K%0d valid", n), {63'd0, valid}, 64'd1);
      chk($sformatf("K%0d busy", n), {63'd0, busy}, 64'd1);
      chk($sformatf("K%0d done", n), {63'd0, done}, 64'd0);
      if (n == stall_at) begin
        ack = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          chk($sformatf("stall K%0d key", n), {16'd0, rk}, {16'd0, mk[n]});
          chk($sformatf("stall K%0d num", n), {60'd0, rn}, {60'd0, 4'(n)});
          chk($sformatf("stall K%0d valid", n), {63'd0, valid}, 64'd1);
        end
        ack = 1'b1;
      end
      if (n == intr_at) begin
        start = 1'b1;
        key = intr_key;
      end
      if (chain && n == 1) begin
        start = 1'b1;
        key = chain_key;
      end
      step();
      if (!(chain && n == 1)) begin
        start = 1'b0;
        key = ~k;
      end
    end
    chk("done pulse", {63'd0, done}, 64'd1);
    chk("done valid", {63'd0, valid}, 64'd0);
    chk("done busy", {63'd0, busy}, 64'd0);
    if (chain) begin
      step();
      return;
    end
    step();
    chk("post done", {63'd0, done}, 64'd0);
    chk("post busy", {63'd0, busy}, 64'd0);
    chk("post valid", {63'd0, valid}, 64'd0);
    ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:63] rkey;
    tbl[0] = '{64'h133457799BBCDFF1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    tbl[1] = '{64'hFEFEFEFEFEFEFEFE, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
    tbl[2] = '{64'h0101010101010101, 48'h000000000000, 48'h000000000000};

    repeat (2) step();
    chk("rst key", {16'd0, rk}, 64'd0);
    chk("rst num", {60'd0, rn}, 64'd0);
    chk("rst valid", {63'd0, valid}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst perr", {63'd0, perr}, 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 3; i++) begin
      run_sched(g16, g1, tbl[i].key, 0, 0, 0, '0, 1'b0, '0, 1'b0);
      chk($sformatf("tbl%0d K16", i), {16'd0, g16}, {16'd0, tbl[i].k16});
      chk($sformatf("tbl%0d K1", i), {16'd0, g1}, {16'd0, tbl[i].k1});
    end

    run_sched(g16, g1, tbl[0].key, 9, 5, 0, '0, 1'b0, '0, 1'b0);
    chk("stall K1", {16'd0, g1}, {16'd0, tbl[0].k1});

    run_sched(g16, g1, tbl[0].key, 0, 0, 12, 64'h0123456789ABCDEF,
              1'b0, '0, 1'b0);
    chk("intr K1", {16'd0, g1}, {16'd0, tbl[0].k1});

    model(tbl[0].key);
    start = 1'b1;
    key = tbl[0].key;
    ack = 1'b1;
    step();
    start = 1'b0;
    key = '0;
`ifdef DES_KEY_PARITY_CHECK_EN
    step();
`endif
    repeat (9) step();
    chk("pre-rst num", {60'd0, rn}, 64'd7);
    chk("pre-rst key", {16'd0, rk}, {16'd0, mk[7]});
    reset = 1'b1;
    #1;
    chk("mid-rst key", {16'd0, rk}, 64'd0);
    chk("mid-rst num", {60'd0, rn}, 64'd0);
    chk("mid-rst valid", {63'd0, valid}, 64'd0);
    chk("mid-rst busy", {63'd0, busy}, 64'd0);
    chk("mid-rst done", {63'd0, done}, 64'd0);
    chk("mid-rst perr", {63'd0, perr}, 64'd0);
    for (int s = 0; s < 2; s++) begin
      step();
      chk("rst hold done", {63'd0, done}, 64'd0);
    end
    reset = 1'b0;
    ack = 1'b0;
    step();
    run_sched(g16, g1, tbl[0].key, 0, 0, 0, '0, 1'b0, '0, 1'b0);
    chk("after rst K16", {16'd0, g16}, {16'd0, tbl[0].k16});

`ifdef DES_KEY_PARITY_CHECK_EN
    start = 1'b1;
    key = '0;
    step();
    start = 1'b0;
    chk("zero load perr", {63'd0, perr}, 64'd0);
    chk("zero load valid", {63'd0, valid}, 64'd0);
    step();
    chk("zero perr pulse", {63'd0, perr}, 64'd1);
    chk("zero valid", {63'd0, valid}, 64'd0);
    chk("zero busy", {63'd0, busy}, 64'd0);
    step();
    chk("zero perr end", {63'd0, perr}, 64'd0);
    chk("zero valid end", {63'd0, valid}, 64'd0);
    chk("zero done", {63'd0, done}, 64'd0);
`else
    run_sched(g16, g1, 64'd0, 0, 0, 0, '0, 1'b0, '0, 1'b0);
    chk("zero K16", {16'd0, g16}, 64'd0);
    chk("zero perr", {63'd0, perr}, 64'd0);
`endif

    run_sched(g16, g1, tbl[0].key, 0, 0, 0, '0,
              1'b1, 64'h0123456789ABCDEF, 1'b0);
    run_sched(g16, g1, 64'h0123456789ABCDEF, 0, 0, 0, '0,
              1'b0, '0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rkey = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) rkey[8*b + 7] = ~(^rkey[8*b +: 7]);
      run_sched(g16, g1, rkey, int'($urandom_range(1, 16)),
                int'($urandom_range(1, 3)), 0, '0, 1'b0, '0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_decrypt_key_scheduler.md
DES_DECRYPT_KEY_SCHEDULER -- requirements
Module: des_decrypt_key_scheduler

Interface
REQ-001 SHALL have no parameters; all widths are fixed by DES, and bit 0 is the MSB on every vector port.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start_strobe_din, input, 1 bit: one-cycle request to begin a schedule.
REQ-005 SHALL have port key_din, input, [0:63]: 64-bit DES key including parity bits, sampled with start_strobe_din.
REQ-006 SHALL have port round_key_ack_din, input, 1 bit: consumer accepts the presented round key.
REQ-007 SHALL have port round_key_dout, output, [0:47]: current subkey.
REQ-008 SHALL have port round_key_valid_dout, output, 1 bit: round_key_dout holds a valid subkey.
REQ-009 SHALL have port round_number_dout, output, [3:0]: index of the presented subkey, 16 down to 1, with 16 encoded as 4'd0.
REQ-010 SHALL have port busy_dout, output, 1 bit: a schedule is in progress.
REQ-011 SHALL have port done_strobe_dout, output, 1 bit: one-cycle pulse after subkey 1 is accepted.
REQ-012 SHALL have port parity_error_dout, output, 1 bit: one-cycle pulse on key rejection (see Configuration).

Function
REQ-013 SHALL emit subkeys in decryption order: K16, K15, ..., K1. Each subkey SHALL be bit-identical to the FIPS 46-3 encryption subkey of the same index.
REQ-014 SHALL implement three states, IDLE, LOAD and ROUND, each held in a register.
REQ-015 In IDLE, start_strobe_din=1 SHALL capture PC-1(key_din) into the 28-bit registers C and D and move to ROUND on the next edge. LOAD is used only when REQ-031 applies.
REQ-016 In the first ROUND cycle (one cycle after the start strobe), the outputs SHALL be: round_key_valid_dout=1, round_number_dout=16, round_key_dout=PC-2(C0,D0).
REQ-017 round_key_dout SHALL be pure PC-2 wiring of the registered C and D, so it has no combinational path from any input.
REQ-018 round_key_dout and round_number_dout SHALL stay stable while round_key_valid_dout=1 and round_key_ack_din=0; there is no timeout.
REQ-019 On a cycle with valid=1 and ack=1 for round n>1, C and D SHALL rotate right by 1 if n is 16, 9 or 2 and by 2 otherwise. The next subkey SHALL appear on the following cycle, giving a throughput of 1 subkey per cycle under continuous ack.
REQ-020 On ack of round 1, valid SHALL drop on the next cycle, done_strobe_dout SHALL be 1 for that one cycle, and the state SHALL return to IDLE.
REQ-021 round_key_ack_din while valid=0 SHALL be ignored.
REQ-022 start_strobe_din while busy_dout=1 SHALL be ignored; the current schedule continues unchanged.
REQ-023 If start and the round-1 ack coincide, the start SHALL be ignored. A new start is accepted from the cycle done_strobe_dout is high, because the state is already IDLE then.
REQ-024 busy_dout SHALL be 1 exactly while the state is not IDLE.
REQ-025 The cumulative right rotation over a full schedule SHALL be 28, so C and D end equal to C0 and D0.

Reset
REQ-026 Reset SHALL force, asynchronously: state=IDLE, C=D=0, and all outputs 0 (round_key_dout=0, round_number_dout=0, valid, busy, done and parity_error all 0).
REQ-027 Reset asserted mid-schedule SHALL abort the schedule with no done_strobe_dout. The first start after reset deasserts SHALL begin again from K16.
REQ-028 Reset deassertion SHALL take effect at the next clk edge, and no start is accepted in the deassertion cycle.

Configuration
REQ-029 Macro DES_KEY_PARITY_CHECK_EN SHALL control the key parity check.
REQ-030 With the macro defined, an accepted start SHALL move the state to LOAD for one cycle, in which the odd parity of every key byte is checked. This SHALL add one cycle of latency, so K16 is valid 2 cycles after start.
REQ-031 With the macro defined and any key byte at even parity, the block SHALL pulse parity_error_dout for 1 cycle, emit no subkeys and no done_strobe_dout, and return to IDLE.
REQ-032 With the macro undefined, there SHALL be no check and no LOAD state, and parity_error_dout SHALL be tied to 0.

Verification
REQ-033 SHALL test: key 133457799BBCDFF1, start, ack held high -> K16=CB3D8B0E17F5 one cycle after start, K1=1B02EFFC7072 fifteen cycles later, then done for 1 cycle. With the macro, each time shifts by +1 cycle.
REQ-034 SHALL test: the same key, ack stalled 5 cycles on round 9 -> key and round number held constant, and the sequence resumes correctly afterwards.
REQ-035 SHALL test: a start during round 12 with key 0123456789ABCDEF -> ignored, and the original schedule completes.
REQ-036 SHALL test: reset asserted during round 7 -> all outputs 0 immediately with no done; after release, a start with the same key gives K16 first.
REQ-037 SHALL test: with the macro defined, key 0000000000000000 -> parity_error_dout pulses once, valid never rises, busy=0 after 2 cycles. Without the macro, K16=PC-2(0)=000000000000 is emitted.
REQ-038 SHALL test: a start in the same cycle as done_strobe_dout -> accepted, and the new schedule begins with K16 on the next cycle.
